// File: rtl/audio_mem_sequencer_pkg.sv
// Shared definitions for the audio PSRAM sequencer and other PSRAM clients.
// Holds the sequencer state encoding and the default async-PSRAM timing.
package audio_mem_sequencer_pkg;

    localparam int unsigned PSRAM_ACCESS_CYCLES  = 8;
    localparam int unsigned PSRAM_RECOVER_CYCLES = 2;

    typedef enum logic [2:0] {
        StIdle,
        StRecWait,
        StRecAcc,
        StRecRcv,
        StPlayWait,
        StPlayAcc,
        StPlayRcv
    } seq_state_e;

    // Counter width able to hold (max(a, b) - 1).
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/audio_mem_sequencer_access_timer.sv
// Load/countdown phase timer; o_tc marks the last cycle of a loaded phase.
// A phase loaded with N-1 therefore lasts exactly N cycles.
module audio_mem_sequencer_access_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/audio_mem_sequencer.sv
// Record/playback sequencer feeding the cellular-RAM access block.
// Turns sample strobes into single timed PSRAM reads/writes at incrementing addresses.
module audio_mem_sequencer
    import audio_mem_sequencer_pkg::*;
#(
    parameter int unsigned        ADDR_W         = 24,
    parameter int unsigned        DATA_W         = 16,
    parameter int unsigned        ACCESS_CYCLES  = PSRAM_ACCESS_CYCLES,
    parameter int unsigned        RECOVER_CYCLES = PSRAM_RECOVER_CYCLES,
    parameter logic [ADDR_W-1:0]  MAX_ADDR       = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rec_start,
    input  logic              play_start,
    input  logic              stop,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_in_valid,
    input  logic              sample_req,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_out_valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dW,
    output logic              RE,
    output logic              WE,
    input  logic [DATA_W-1:0] dR,
    output logic              busy,
    output logic              full,
    output logic              overrun,
    output logic              done,
    output logic [ADDR_W-1:0] rec_len
);

    localparam int unsigned TMR_W = timer_width(ACCESS_CYCLES, RECOVER_CYCLES);
    localparam logic [TMR_W-1:0] ACC_LOAD = TMR_W'(ACCESS_CYCLES - 1);
    localparam logic [TMR_W-1:0] RCV_LOAD = TMR_W'(RECOVER_CYCLES - 1);
    // Length of a recording that filled memory; saturates when MAX_ADDR is all-ones.
    localparam logic [ADDR_W-1:0] LEN_FULL =
        (MAX_ADDR == {ADDR_W{1'b1}}) ? MAX_ADDR : MAX_ADDR + ADDR_W'(1);

    seq_state_e        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_dw, w_dw_nxt;
    logic              r_re, w_re_nxt;
    logic              r_we, w_we_nxt;
    logic [DATA_W-1:0] r_sout, w_sout_nxt;
    logic              r_sout_v, w_sout_v_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_full, w_full_nxt;
    logic              r_overrun, w_overrun_nxt;
    logic              r_done, w_done_nxt;
    logic [ADDR_W-1:0] r_rec_len, w_rec_len_nxt;
    logic              r_hold_v, w_hold_v_nxt;
    logic [DATA_W-1:0] r_hold_d, w_hold_d_nxt;
    logic              r_stop_pend, w_stop_pend_nxt;
    logic              r_req_pend, w_req_pend_nxt;

    logic              w_tmr_load;
    logic [TMR_W-1:0]  w_tmr_val;
    logic              w_tmr_tc;
    logic              w_hold_take;
    logic              w_in_rec;
    logic              w_in_play;
    logic              w_stop;

    audio_mem_sequencer_access_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_tc       (w_tmr_tc)
    );

    assign w_in_rec  = (r_state inside {StRecWait, StRecAcc, StRecRcv});
    assign w_in_play = (r_state inside {StPlayWait, StPlayAcc, StPlayRcv});
    assign w_stop    = stop | r_stop_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_ptr       <= '0;
            r_addr      <= '0;
            r_dw        <= '0;
            r_re        <= 1'b0;
            r_we        <= 1'b0;
            r_sout      <= '0;
            r_sout_v    <= 1'b0;
            r_busy      <= 1'b0;
            r_full      <= 1'b0;
            r_overrun   <= 1'b0;
            r_done      <= 1'b0;
            r_rec_len   <= '0;
            r_hold_v    <= 1'b0;
            r_hold_d    <= '0;
            r_stop_pend <= 1'b0;
            r_req_pend  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_addr      <= w_addr_nxt;
            r_dw        <= w_dw_nxt;
            r_re        <= w_re_nxt;
            r_we        <= w_we_nxt;
            r_sout      <= w_sout_nxt;
            r_sout_v    <= w_sout_v_nxt;
            r_busy      <= w_busy_nxt;
            r_full      <= w_full_nxt;
            r_overrun   <= w_overrun_nxt;
            r_done      <= w_done_nxt;
            r_rec_len   <= w_rec_len_nxt;
            r_hold_v    <= w_hold_v_nxt;
            r_hold_d    <= w_hold_d_nxt;
            r_stop_pend <= w_stop_pend_nxt;
            r_req_pend  <= w_req_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_addr_nxt      = r_addr;
        w_dw_nxt        = r_dw;
        w_re_nxt        = r_re;
        w_we_nxt        = r_we;
        w_sout_nxt      = r_sout;
        w_sout_v_nxt    = 1'b0;
        w_full_nxt      = r_full;
        w_overrun_nxt   = r_overrun;
        w_done_nxt      = 1'b0;
        w_rec_len_nxt   = r_rec_len;
        w_hold_v_nxt    = r_hold_v;
        w_hold_d_nxt    = r_hold_d;
        w_stop_pend_nxt = r_stop_pend;
        w_req_pend_nxt  = r_req_pend;
        w_tmr_load      = 1'b0;
        w_tmr_val       = '0;
        w_hold_take     = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (rec_start) begin
                    w_ptr_nxt     = '0;
                    w_full_nxt    = 1'b0;
                    w_overrun_nxt = 1'b0;
                    w_state_nxt   = StRecWait;
                end else if (play_start) begin
                    w_ptr_nxt   = '0;
                    w_state_nxt = StPlayWait;
                end
            end
            StRecWait: begin
                if (w_stop) begin
                    w_rec_len_nxt = r_ptr;
                    w_state_nxt   = StIdle;
                end else if (r_hold_v) begin
                    w_addr_nxt   = r_ptr;
                    w_dw_nxt     = r_hold_d;
                    w_we_nxt     = 1'b1;
                    w_hold_v_nxt = 1'b0;
                    w_hold_take  = 1'b1;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = ACC_LOAD;
                    w_state_nxt  = StRecAcc;
                end
            end
            StRecAcc: begin
                if (w_tmr_tc) begin
                    w_we_nxt    = 1'b0;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = RCV_LOAD;
                    w_state_nxt = StRecRcv;
                end
            end
            StRecRcv: begin
                if (w_tmr_tc) begin
                    w_ptr_nxt = r_ptr + ADDR_W'(1);
                    if (r_ptr == MAX_ADDR) begin
                        w_full_nxt    = 1'b1;
                        w_rec_len_nxt = LEN_FULL;
                        w_state_nxt   = StIdle;
                    end else if (w_stop) begin
                        w_rec_len_nxt = r_ptr + ADDR_W'(1);
                        w_state_nxt   = StIdle;
                    end else begin
                        w_state_nxt = StRecWait;
                    end
                end
            end
            StPlayWait: begin
                if (w_stop) begin
                    w_state_nxt = StIdle;
                end else if (r_ptr == r_rec_len) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = StIdle;
                end else if (r_req_pend) begin
                    w_addr_nxt     = r_ptr;
                    w_re_nxt       = 1'b1;
                    w_req_pend_nxt = 1'b0;
                    w_tmr_load     = 1'b1;
                    w_tmr_val      = ACC_LOAD;
                    w_state_nxt    = StPlayAcc;
                end
            end
            StPlayAcc: begin
                if (w_tmr_tc) begin
                    w_sout_nxt   = dR;
                    w_sout_v_nxt = 1'b1;
                    w_re_nxt     = 1'b0;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = RCV_LOAD;
                    w_state_nxt  = StPlayRcv;
                end
            end
            StPlayRcv: begin
                if (w_tmr_tc) begin
                    w_ptr_nxt   = r_ptr + ADDR_W'(1);
                    w_state_nxt = w_stop ? StIdle : StPlayWait;
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        // A sample arriving as the held one is written still fits.
        if (w_in_rec && sample_in_valid) begin
            if (r_hold_v && !w_hold_take) begin
                w_overrun_nxt = 1'b1;
            end else begin
                w_hold_v_nxt = 1'b1;
                w_hold_d_nxt = sample_in;
            end
        end
        if ((w_in_rec || w_in_play) && stop) begin
            w_stop_pend_nxt = 1'b1;
        end
        if (w_in_play && sample_req && !r_req_pend) begin
            w_req_pend_nxt = 1'b1;
        end
        if (w_state_nxt == StIdle) begin
            w_hold_v_nxt    = 1'b0;
            w_stop_pend_nxt = 1'b0;
            w_req_pend_nxt  = 1'b0;
        end
        w_busy_nxt = (w_state_nxt != StIdle);
    end

    assign sample_out       = r_sout;
    assign sample_out_valid = r_sout_v;
    assign addr             = r_addr;
    assign dW               = r_dw;
    assign RE               = r_re;
    assign WE               = r_we;
    assign busy             = r_busy;
    assign full             = r_full;
    assign overrun          = r_overrun;
    assign done             = r_done;
    assign rec_len          = r_rec_len;

endmodule

// File: tb/tb_audio_mem_sequencer.sv
// Directed bench for audio_mem_sequencer with a small PSRAM model and bus monitor.
// A second instance with a tiny MAX_ADDR exercises the full-memory stop.
module tb_audio_mem_sequencer;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              rec_start = 1'b0, play_start = 1'b0, stop = 1'b0;
    logic [DATA_W-1:0] sample_in = '0;
    logic              sample_in_valid = 1'b0, sample_req = 1'b0;

    logic [DATA_W-1:0] sample_out, dW, dR;
    logic              sample_out_valid, RE, WE, busy, full, overrun, done;
    logic [ADDR_W-1:0] addr, rec_len;

    logic [DATA_W-1:0] m_sample_out, m_dW;
    logic              m_sample_out_valid, m_RE, m_WE, m_busy, m_full, m_overrun, m_done;
    logic [ADDR_W-1:0] m_addr, m_rec_len;

    audio_mem_sequencer #(
        .ACCESS_CYCLES  (4),
        .RECOVER_CYCLES (2)
    ) dut (
        .clk (clk), .rst_n (rst_n), .rec_start (rec_start), .play_start (play_start),
        .stop (stop), .sample_in (sample_in), .sample_in_valid (sample_in_valid),
        .sample_req (sample_req), .sample_out (sample_out),
        .sample_out_valid (sample_out_valid), .addr (addr), .dW (dW), .RE (RE), .WE (WE),
        .dR (dR), .busy (busy), .full (full), .overrun (overrun), .done (done),
        .rec_len (rec_len)
    );

    audio_mem_sequencer #(
        .ACCESS_CYCLES  (4),
        .RECOVER_CYCLES (2),
        .MAX_ADDR       (24'h000003)
    ) dut_m (
        .clk (clk), .rst_n (rst_n), .rec_start (rec_start), .play_start (play_start),
        .stop (stop), .sample_in (sample_in), .sample_in_valid (sample_in_valid),
        .sample_req (sample_req), .sample_out (m_sample_out),
        .sample_out_valid (m_sample_out_valid), .addr (m_addr), .dW (m_dW), .RE (m_RE),
        .WE (m_WE), .dR (16'h0000), .busy (m_busy), .full (m_full), .overrun (m_overrun),
        .done (m_done), .rec_len (m_rec_len)
    );

    // PSRAM model for the main instance
    logic [DATA_W-1:0] mem [16];
    always @(posedge clk) if (WE) mem[addr[3:0]] <= dW;
    assign dR = RE ? mem[addr[3:0]] : 16'h0000;

    // Bus monitor (sampled on the inactive edge)
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [DATA_W-1:0] wr_data_q[$];
    int                wr_len_q[$];
    logic [ADDR_W-1:0] rd_addr_q[$];
    logic [DATA_W-1:0] out_q[$];
    int                we_run = 0, re_run = 0, valid_cycles = 0, done_cnt = 0, m_wr_cnt = 0;
    logic              m_we_prev = 1'b0, overlap = 1'b0;
    logic [ADDR_W-1:0] m_last_addr = '0;

    always @(negedge clk) begin
        if (WE) begin
            if (we_run == 0) begin
                wr_addr_q.push_back(addr);
                wr_data_q.push_back(dW);
            end
            we_run++;
        end else if (we_run > 0) begin
            wr_len_q.push_back(we_run);
            we_run = 0;
        end
        if (RE) begin
            if (re_run == 0) rd_addr_q.push_back(addr);
            re_run++;
        end else begin
            re_run = 0;
        end
        if (sample_out_valid) begin
            valid_cycles++;
            out_q.push_back(sample_out);
        end
        if (done) done_cnt++;
        if ((RE && WE) || (m_RE && m_WE)) overlap = 1'b1;
        if (m_WE && !m_we_prev) begin
            m_wr_cnt++;
            m_last_addr = m_addr;
        end
        m_we_prev = m_WE;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int wb, lb, rb, ob, vb, db, mb;

    initial begin
        // Reset state
        tick(3);
        rst_n = 1'b1;
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_we_re", {30'd0, RE, WE}, 0);
        chk("rst_rec_len", 32'(rec_len), 0);
        chk("rst_flags", {28'd0, full, overrun, done, sample_out_valid}, 0);

        // Reset in the middle of a write access
        rec_start = 1'b1; tick(); rec_start = 1'b0;
        sample_in = 16'hAAAA; sample_in_valid = 1'b1; tick(); sample_in_valid = 1'b0;
        tick(10);
        sample_in = 16'hBBBB; sample_in_valid = 1'b1; tick(); sample_in_valid = 1'b0;
        tick();
        chk("pre_rst_we", 32'(WE), 1);
        chk("pre_rst_addr", 32'(addr), 1);
        chk("pre_rst_dw", 32'(dW), 32'hBBBB);
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_rst_we", 32'(WE), 0);
        chk("async_rst_addr", 32'(addr), 0);
        chk("async_rst_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick(2);

        // Record three spaced samples, then stop
        wb = wr_addr_q.size(); lb = wr_len_q.size();
        rec_start = 1'b1; tick(); rec_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample_in = 16'(16'h1111 * (i + 1));
            sample_in_valid = 1'b1; tick(); sample_in_valid = 1'b0;
            tick(19);
        end
        chk("rec_busy", 32'(busy), 1);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("rec_len3", 32'(rec_len), 3);
        chk("rec_idle", 32'(busy), 0);
        tick(2);
        chk("rec_nwrites", 32'(wr_addr_q.size() - wb), 3);
        for (int i = 0; i < 3; i++) begin
            chk("rec_addr", 32'(wr_addr_q[wb + i]), 32'(i));
            chk("rec_data", 32'(wr_data_q[wb + i]), 32'(16'h1111 * (i + 1)));
            chk("rec_we_len", 32'(wr_len_q[lb + i]), 4);
        end

        // Play the recording back
        rb = rd_addr_q.size(); ob = out_q.size(); vb = valid_cycles; db = done_cnt;
        play_start = 1'b1; tick(); play_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample_req = 1'b1; tick(); sample_req = 1'b0;
            tick(29);
        end
        chk("play_valid_cycles", 32'(valid_cycles - vb), 3);
        chk("play_nreads", 32'(rd_addr_q.size() - rb), 3);
        for (int i = 0; i < 3; i++) begin
            chk("play_data", 32'(out_q[ob + i]), 32'(16'h1111 * (i + 1)));
            chk("play_addr", 32'(rd_addr_q[rb + i]), 32'(i));
        end
        chk("play_done", 32'(done_cnt - db), 1);
        chk("play_idle", 32'(busy), 0);

        // Back-to-back samples overrun the holding register
        wb = wr_addr_q.size();
        rec_start = 1'b1; tick(); rec_start = 1'b0;
        sample_in_valid = 1'b1;
        sample_in = 16'h4444; tick();
        sample_in = 16'h5555; tick();
        sample_in = 16'h6666; tick();
        sample_in_valid = 1'b0;
        tick(25);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("ovr_flag", 32'(overrun), 1);
        chk("ovr_rec_len", 32'(rec_len), 2);
        chk("ovr_nwrites", 32'(wr_addr_q.size() - wb), 2);
        chk("ovr_w0", {8'd0, wr_addr_q[wb], wr_data_q[wb]}, 32'h0000_4444);
        chk("ovr_w1", {8'd0, wr_addr_q[wb + 1], wr_data_q[wb + 1]}, 32'h0001_5555);

        // Simultaneous starts: record wins, immediate stop leaves an empty recording
        wb = wr_addr_q.size();
        rec_start = 1'b1; play_start = 1'b1; tick();
        rec_start = 1'b0; play_start = 1'b0;
        chk("both_busy", 32'(busy), 1);
        chk("both_ovr_clr", 32'(overrun), 0);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("both_rec_len", 32'(rec_len), 0);
        chk("both_idle", 32'(busy), 0);

        // Playback of an empty recording
        rb = rd_addr_q.size();
        play_start = 1'b1; tick(); play_start = 1'b0;
        chk("empty_done_early", 32'(done), 0);
        tick();
        chk("empty_done", 32'(done), 1);
        tick();
        chk("empty_done_clr", {30'd0, done, busy}, 0);
        chk("empty_no_re", 32'(rd_addr_q.size() - rb), 0);
        chk("empty_no_we", 32'(wr_addr_q.size() - wb), 0);

        // Small MAX_ADDR instance fills after four words
        mb = m_wr_cnt;
        rec_start = 1'b1; tick(); rec_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample_in = 16'(16'h0101 * (i + 1));
            sample_in_valid = 1'b1; tick(); sample_in_valid = 1'b0;
            tick(14);
        end
        tick(10);
        chk("max_full", 32'(m_full), 1);
        chk("max_rec_len", 32'(m_rec_len), 4);
        chk("max_idle", 32'(m_busy), 0);
        chk("max_nwrites", 32'(m_wr_cnt - mb), 4);
        chk("max_last_addr", 32'(m_last_addr), 3);
        chk("main_not_full", 32'(full), 0);
        stop = 1'b1; tick(); stop = 1'b0;
        tick(10);

        chk("re_we_overlap", 32'(overlap), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
